dmem_lane_ram: RTL and testbench
================================

// Module: dmem_lane_ram
// PURPOSE
//  Parametrised byte-lane data memory for the core's LSU; successor to the fixed 8-bit x 16k lane RAMs.
//  Holds LANES lane banks with byte-enable writes and registered (1-cycle) reads.
//  Misaligned accesses that cross a row are split into two internal phases by a small FSM.
//  Uses a req/ready request channel and a single-pulse response.
// PARAMETERS
//  LANES   4      byte lanes per row; power of 2, >=2
//  LANE_W  8      bits per lane
//  DEPTH   16384  rows per lane bank; power of 2
//  ADDR_W  $clog2(DEPTH*LANES)  byte-address width (derived, localparam)
// PORTS
//  clk_i        in   1               clock, rising edge
//  rst_ni       in   1               async active-low reset
//  req_i        in   1               access request
//  we_i         in   1               1 = write, 0 = read
//  addr_i       in   ADDR_W          byte address of access start
//  be_i         in   LANES           byte enables; bit i = byte addr_i+i
//  wdata_i      in   LANES*LANE_W    write data; byte i = byte addr_i+i
//  ready_o      out  1               request accepted when req_i && ready_o
//  rsp_valid_o  out  1               one-cycle pulse: access complete
//  rdata_o      out  LANES*LANE_W    read data, LSB-aligned to addr_i
//  err_o        out  1               misaligned-access error, valid with rsp_valid_o
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state=IDLE; ready_o=1; rsp_valid_o=0; rdata_o=0; err_o=0; hold reg=0.
//    Array contents are not reset.
//  - off = addr_i[$clog2(LANES)-1:0]; row = addr_i[ADDR_W-1:$clog2(LANES)]; top = index of highest set be_i bit.
//    be_i=0 is legal: the access is a no-op and still returns a response.
//  - Fits: (off+top) < LANES. Access completes in one phase.
//    Accept at T; rsp_valid_o at T+1; ready_o stays 1.
//  - Crosses: (off+top) >= LANES. Handled only when DMEM_MISALIGN_EN is defined.
//      Phase 1 (T): row r, lanes off..LANES-1.
//      Phase 2 (T+1): row r+1, lanes 0..off+top-LANES.
//      ready_o=0 during T+1; rsp_valid_o at T+2.
//  - Inputs are captured at acceptance; the second phase uses the captured copy.
//  - Row wrap: r+1 is computed modulo DEPTH, so the last row wraps to row 0.
//  - Lane mapping: mem lane (off+i) mod LANES <-> request byte i.
//    Rotate on write; inverse-rotate on read.
//  - Reads: rdata_o byte i = mem[addr_i+i] where be_i[i]=1; otherwise 0.
//    rdata_o holds its value until the next response; it is 0 for writes.
//  - Ordering: single port, one phase per cycle. A write accepted at T is visible to a read accepted at T+1.
//  - FSM states:
//      IDLE -(accept & cross & EN)-> SPLIT
//      SPLIT -> IDLE (unconditional)
//      otherwise IDLE -> IDLE
//  - Reset in SPLIT: phase 2 is abandoned and no response is issued.
//    Phase-1 writes already committed remain in memory.
//  - Requests while ready_o=0 are ignored; the requester must hold req_i.
// CONFIGURATION
//  DMEM_MISALIGN_EN defined: row-crossing accesses are split as above; err_o is tied 0.
//  DMEM_MISALIGN_EN undefined: no SPLIT state; ready_o is tied 1.
//    A crossing access performs only the in-row lanes (off..LANES-1) in one phase.
//    err_o=1 with rsp_valid_o at T+1; out-of-row read bytes are 0.
// STRUCTURE
//  Package dmem_pkg:
//    dmem_state_e {IDLE, SPLIT};
//    default LANES/LANE_W/DEPTH constants;
//    functions rot_l/rot_r (lane rotation by off).
//  Sub-module dmem_lane_bank (LANE_W x DEPTH, write enable, registered read), instantiated LANES times via generate.
//  Top level holds the FSM, capture/hold registers, rotation and per-lane row select (r or r+1).
// TESTING
//  1 Reset: assert rst_ni=0 mid-run -> ready_o=1, rsp_valid_o=0, rdata_o=0, err_o=0 immediately.
//  2 Aligned: write addr 0x10, be 4'hF, data 32'hDEADBEEF; read 0x10
//    -> rsp each at T+1; rdata_o=32'hDEADBEEF.
//  3 Partial: write 0x21 be 4'b0011 data 32'h0000A55A; read 0x20 be 4'hF
//    -> rdata_o=32'h00A55A00 (other bytes from prior zeros).
//  4 Split (EN): write 0x1E be 4'hF data 32'h11223344; read 0x1E
//    -> ready_o low 1 cycle, rsp at T+2, rdata_o=32'h11223344; read 0x20 -> byte0=8'h22.
//  5 Wrap (EN): write byte addr DEPTH*LANES-2, be 4'hF, data 32'hCAFEF00D
//    -> read addr 0 be 4'b0011 returns 32'h0000CAFE.
//  6 No EN: read 0x1F be 4'hF -> err_o=1 at T+1, rdata_o[31:8]=0; reset during SPLIT (EN) -> no rsp pulse.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, default geometry and lane-rotation helpers for the lane RAM.
package dmem_pkg;

    localparam int DMEM_LANES  = 4;
    localparam int DMEM_LANE_W = 8;
    localparam int DMEM_DEPTH  = 16384;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } dmem_state_e;

    // Request byte idx lives in memory lane (idx + off) mod lanes; lanes is a power of 2.
    function automatic int unsigned rot_l(int unsigned idx, int unsigned off, int unsigned lanes);
        return (idx + off) & (lanes - 1);
    endfunction

    function automatic int unsigned rot_r(int unsigned idx, int unsigned off, int unsigned lanes);
        return (idx + lanes - off) & (lanes - 1);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response channel of the lane RAM.
// A request is taken on a rising edge where req_i && ready_o; rsp_valid_o pulses once when it completes.
interface dmem_if #(
    parameter int LANES  = dmem_pkg::DMEM_LANES,
    parameter int LANE_W = dmem_pkg::DMEM_LANE_W,
    parameter int DEPTH  = dmem_pkg::DMEM_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH * LANES);

    logic                      req_i;
    logic                      we_i;
    logic [ADDR_W-1:0]         addr_i;
    logic [LANES-1:0]          be_i;
    logic [LANES*LANE_W-1:0]   wdata_i;
    logic                      ready_o;
    logic                      rsp_valid_o;
    logic [LANES*LANE_W-1:0]   rdata_o;
    logic                      err_o;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i,
        input  ready_o, rsp_valid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i,
        output ready_o, rsp_valid_o, rdata_o, err_o
    );

endinterface

// File: rtl/dmem_lane_bank.sv
// dmem_lane_bank: one LANE_W x DEPTH byte lane with write enable and registered read.
module dmem_lane_bank
    import dmem_pkg::*;
#(
    parameter int LANE_W = DMEM_LANE_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_en,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [LANE_W-1:0]        i_wdata,
    output logic [LANE_W-1:0]        o_rdata
);
    logic [LANE_W-1:0] r_mem [DEPTH];
    logic [LANE_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_lane_ram.sv
// dmem_lane_ram: byte-lane data memory with registered reads for the LSU.
// Define DMEM_MISALIGN_EN to split row-crossing accesses into two phases; otherwise they flag err_o.
module dmem_lane_ram
    import dmem_pkg::*;
#(
    parameter int LANES  = DMEM_LANES,
    parameter int LANE_W = DMEM_LANE_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    dmem_if.slave       bus,
    output dmem_state_e dbg_state_o
);
    localparam int OFF_W  = $clog2(LANES);
    localparam int ROW_W  = $clog2(DEPTH);
    localparam int ADDR_W = ROW_W + OFF_W;
    localparam int DATA_W = LANES * LANE_W;

    dmem_state_e       r_state, w_state_nxt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [LANES-1:0]  r_be;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp, r_rd, r_split, r_err;
    logic [OFF_W-1:0]  r_off;
    logic [LANES-1:0]  r_rbe;
    logic [DATA_W-1:0] r_acc, r_rdata;

    logic              w_ready, w_accept, w_cross, w_err_in, w_phase2, w_active, w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [LANES-1:0]  w_be, w_lane_we;
    logic [DATA_W-1:0] w_wdata, w_lane_wdata, w_lane_rdata, w_rdata;
    logic [OFF_W-1:0]  w_off;
    logic [ROW_W-1:0]  w_row;

`ifdef DMEM_MISALIGN_EN
    localparam bit SPLIT_EN = 1'b1;
    assign w_ready = (r_state == IDLE);
`else
    localparam bit SPLIT_EN = 1'b0;
    assign w_ready = 1'b1;
`endif

    assign w_accept = bus.req_i && w_ready;
    assign w_err_in = w_cross && !SPLIT_EN;

    always_comb begin
        w_cross = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.be_i[i] && (int'(bus.addr_i[OFF_W-1:0]) + i >= LANES)) w_cross = 1'b1;
        end
    end

    // Phase 2 replays the captured request against the next row (wrapping at DEPTH).
    assign w_phase2 = (r_state == SPLIT);
    assign w_active = w_accept || w_phase2;
    assign w_we     = w_phase2 ? r_we    : bus.we_i;
    assign w_addr   = w_phase2 ? r_addr  : bus.addr_i;
    assign w_be     = w_phase2 ? r_be    : bus.be_i;
    assign w_wdata  = w_phase2 ? r_wdata : bus.wdata_i;
    assign w_off    = w_addr[OFF_W-1:0];
    assign w_row    = w_addr[ADDR_W-1:OFF_W] + ROW_W'(w_phase2);

    always_comb begin
        w_lane_we    = '0;
        w_lane_wdata = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_wdata[l*LANE_W +: LANE_W] = w_wdata[rot_r(l, 32'(w_off), LANES)*LANE_W +: LANE_W];
            w_lane_we[l] = w_active && w_we && w_be[rot_r(l, 32'(w_off), LANES)] &&
                           ((l >= int'(w_off)) != w_phase2);
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dmem_lane_bank #(.LANE_W(LANE_W), .DEPTH(DEPTH)) u_bank (
            .i_clk   (clk_i),
            .i_en    (w_active),
            .i_we    (w_lane_we[l]),
            .i_addr  (w_row),
            .i_wdata (w_lane_wdata[l*LANE_W +: LANE_W]),
            .o_rdata (w_lane_rdata[l*LANE_W +: LANE_W])
        );
    end

    // In-row bytes of a split read were parked in r_acc; next-row bytes arrive from the banks now.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_rd && r_rbe[i]) begin
                if (int'(r_off) + i < LANES) begin
                    w_rdata[i*LANE_W +: LANE_W] = r_split ?
                        r_acc[rot_l(i, 32'(r_off), LANES)*LANE_W +: LANE_W] :
                        w_lane_rdata[rot_l(i, 32'(r_off), LANES)*LANE_W +: LANE_W];
                end else if (r_split) begin
                    w_rdata[i*LANE_W +: LANE_W] = w_lane_rdata[rot_l(i, 32'(r_off), LANES)*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_cross && SPLIT_EN) w_state_nxt = SPLIT;
            SPLIT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rsp   <= 1'b0;
            r_rd    <= 1'b0;
            r_split <= 1'b0;
            r_err   <= 1'b0;
            r_off   <= '0;
            r_rbe   <= '0;
            r_acc   <= '0;
            r_rdata <= '0;
        end else begin
            r_rsp <= 1'b0;
            if (w_accept) begin
                r_we    <= bus.we_i;
                r_addr  <= bus.addr_i;
                r_be    <= bus.be_i;
                r_wdata <= bus.wdata_i;
            end
            if (w_phase2) begin
                r_rsp   <= 1'b1;
                r_rd    <= !r_we;
                r_split <= 1'b1;
                r_err   <= 1'b0;
                r_off   <= r_addr[OFF_W-1:0];
                r_rbe   <= r_be;
                r_acc   <= w_lane_rdata;
            end else if (w_accept && !(w_cross && SPLIT_EN)) begin
                r_rsp   <= 1'b1;
                r_rd    <= !bus.we_i;
                r_split <= 1'b0;
                r_err   <= w_err_in;
                r_off   <= bus.addr_i[OFF_W-1:0];
                r_rbe   <= bus.be_i;
            end
            if (r_rsp) r_rdata <= w_rdata;
        end
    end

    assign bus.ready_o     = w_ready;
    assign bus.rsp_valid_o = r_rsp;
    assign bus.rdata_o     = r_rsp ? w_rdata : r_rdata;
    assign bus.err_o       = r_rsp && r_err;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_dmem_lane_ram.sv
// tb_dmem_lane_ram: directed self-checking bench for dmem_lane_ram.
// Expectations for row-crossing accesses follow DMEM_MISALIGN_EN.
module tb_dmem_lane_ram;
  import dmem_pkg::*;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int DEPTH  = 16384;

`ifdef DMEM_MISALIGN_EN
  localparam int          CROSS_LAT     = 2;
  localparam logic        CROSS_ERR     = 1'b0;
  localparam logic        CROSS_RDY_LOW = 1'b1;
  localparam logic [31:0] EXP_RD_1E     = 32'h11223344;
  localparam logic [31:0] EXP_RD_1F     = 32'hA5112233;
  localparam logic [31:0] EXP_RD_20     = 32'h00000022;
  localparam logic [31:0] EXP_WRAP      = 32'h0000CAFE;
`else
  localparam int          CROSS_LAT     = 1;
  localparam logic        CROSS_ERR     = 1'b1;
  localparam logic        CROSS_RDY_LOW = 1'b0;
  localparam logic [31:0] EXP_RD_1E     = 32'h00003344;
  localparam logic [31:0] EXP_RD_1F     = 32'h00000033;
  localparam logic [31:0] EXP_RD_20     = 32'h00000000;
  localparam logic [31:0] EXP_WRAP      = 32'h00000000;
`endif

  logic        clk;
  logic        rst_ni;
  dmem_state_e dbg_state;

  dmem_if #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH)) bus ();

  dmem_lane_ram #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_fail;
  logic [31:0] t_rdata;
  logic        t_err;
  int          t_lat;
  logic        t_rdy_low;
  logic        t_ok;

  // Driver: call at a falling edge; returns at the falling edge where rsp_valid_o was seen.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata);
    int waits;
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.be_i    = be;
    bus.wdata_i = wdata;
    waits = 0;
    while (!bus.ready_o && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.ready_o) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout addr=%h ready=%b required=1", addr, bus.ready_o);
    end
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    t_lat = 0; t_rdy_low = 1'b0; t_ok = 1'b0; t_rdata = '0; t_err = 1'b0;
    for (int c = 1; c <= 5 && !t_ok; c++) begin
      @(negedge clk);
      if (!bus.ready_o) t_rdy_low = 1'b1;
      if (bus.rsp_valid_o) begin
        t_ok = 1'b1; t_lat = c; t_rdata = bus.rdata_o; t_err = bus.err_o;
      end
    end
    if (!t_ok) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout addr=%h rsp_valid=%b required=1", addr, bus.rsp_valid_o);
    end
  endtask

  task automatic init_mem();
    do_access(1'b1, 16'h0000, 4'hF, 32'h0);
    do_access(1'b1, 16'h001C, 4'hF, 32'h0);
    do_access(1'b1, 16'h0020, 4'hF, 32'h0);
    do_access(1'b1, 16'h003C, 4'hF, 32'h0);
    do_access(1'b1, 16'h0040, 4'hF, 32'h0);
    do_access(1'b1, 16'hFFFC, 4'hF, 32'h0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (bus.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b req=1", bus.ready_o); end
    n_cmp++;
    if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got=%b req=0", bus.rsp_valid_o); end
    n_cmp++;
    if (bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h req=0", bus.rdata_o); end
    n_cmp++;
    if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b req=0", bus.err_o); end
    n_cmp++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d req=IDLE", dbg_state); end
    n_cmp++;
    rst_ni = 1'b1;
  endtask

  task automatic test_aligned();
    do_access(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
    if (t_lat !== 1) begin n_fail++; $display("FAIL aligned_wr_lat got=%0d req=1", t_lat); end
    n_cmp++;
    if (t_rdata !== 32'h0) begin n_fail++; $display("FAIL aligned_wr_rdata got=%h req=0", t_rdata); end
    n_cmp++;
    do_access(1'b0, 16'h0010, 4'hF, 32'h0);
    if (t_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL aligned_rd_data got=%h req=deadbeef", t_rdata); end
    n_cmp++;
    if (t_lat !== 1) begin n_fail++; $display("FAIL aligned_rd_lat got=%0d req=1", t_lat); end
    n_cmp++;
    if (t_rdy_low !== 1'b0) begin n_fail++; $display("FAIL aligned_ready_drop got=%b req=0", t_rdy_low); end
    n_cmp++;
    @(negedge clk);
    if (bus.rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL aligned_rdata_hold got=%h req=deadbeef", bus.rdata_o); end
    n_cmp++;
  endtask

  task automatic test_partial();
    do_access(1'b1, 16'h0021, 4'b0011, 32'h0000A55A);
    if (t_err !== 1'b0) begin n_fail++; $display("FAIL partial_wr_err got=%b req=0", t_err); end
    n_cmp++;
    do_access(1'b0, 16'h0020, 4'hF, 32'h0);
    if (t_rdata !== 32'h00A55A00) begin n_fail++; $display("FAIL partial_rd_row got=%h req=00a55a00", t_rdata); end
    n_cmp++;
    do_access(1'b0, 16'h0021, 4'b0010, 32'h0);
    if (t_rdata !== 32'h0000A500) begin n_fail++; $display("FAIL partial_rd_be got=%h req=0000a500", t_rdata); end
    n_cmp++;
    do_access(1'b0, 16'h0021, 4'b0000, 32'h0);
    if (t_rdata !== 32'h0 || t_lat !== 1) begin
      n_fail++; $display("FAIL partial_be_zero got=%h/%0d req=0/1", t_rdata, t_lat);
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 16'h0030, 4'hF, 32'h12345678);
    do_access(1'b0, 16'h0030, 4'hF, 32'h0);
    if (t_rdata !== 32'h12345678) begin n_fail++; $display("FAIL b2b_rd got=%h req=12345678", t_rdata); end
    n_cmp++;
    do_access(1'b0, 16'h0032, 4'b0011, 32'h0);
    if (t_rdata !== 32'h00001234) begin n_fail++; $display("FAIL b2b_rd_off2 got=%h req=00001234", t_rdata); end
    n_cmp++;
  endtask

  task automatic test_split();
    do_access(1'b1, 16'h001E, 4'hF, 32'h11223344);
    if (t_lat !== CROSS_LAT) begin n_fail++; $display("FAIL split_wr_lat got=%0d req=%0d", t_lat, CROSS_LAT); end
    n_cmp++;
    if (t_err !== CROSS_ERR) begin n_fail++; $display("FAIL split_wr_err got=%b req=%b", t_err, CROSS_ERR); end
    n_cmp++;
    if (t_rdy_low !== CROSS_RDY_LOW) begin n_fail++; $display("FAIL split_ready_low got=%b req=%b", t_rdy_low, CROSS_RDY_LOW); end
    n_cmp++;
    do_access(1'b0, 16'h001E, 4'hF, 32'h0);
    if (t_rdata !== EXP_RD_1E) begin n_fail++; $display("FAIL split_rd_1e got=%h req=%h", t_rdata, EXP_RD_1E); end
    n_cmp++;
    do_access(1'b0, 16'h001F, 4'hF, 32'h0);
    if (t_rdata !== EXP_RD_1F) begin n_fail++; $display("FAIL split_rd_1f got=%h req=%h", t_rdata, EXP_RD_1F); end
    n_cmp++;
    if (t_err !== CROSS_ERR || t_lat !== CROSS_LAT) begin
      n_fail++; $display("FAIL split_rd_1f_rsp got=%b/%0d req=%b/%0d", t_err, t_lat, CROSS_ERR, CROSS_LAT);
    end
    n_cmp++;
    do_access(1'b0, 16'h0020, 4'b0001, 32'h0);
    if (t_rdata !== EXP_RD_20) begin n_fail++; $display("FAIL split_rd_20 got=%h req=%h", t_rdata, EXP_RD_20); end
    n_cmp++;
  endtask

  task automatic test_wrap();
    do_access(1'b1, 16'hFFFE, 4'hF, 32'hCAFEF00D);
    if (t_err !== CROSS_ERR) begin n_fail++; $display("FAIL wrap_wr_err got=%b req=%b", t_err, CROSS_ERR); end
    n_cmp++;
    do_access(1'b0, 16'h0000, 4'b0011, 32'h0);
    if (t_rdata !== EXP_WRAP) begin n_fail++; $display("FAIL wrap_rd_row0 got=%h req=%h", t_rdata, EXP_WRAP); end
    n_cmp++;
    do_access(1'b0, 16'hFFFE, 4'b0011, 32'h0);
    if (t_rdata !== 32'h0000F00D || t_err !== 1'b0) begin
      n_fail++; $display("FAIL wrap_rd_last got=%h/%b req=0000f00d/0", t_rdata, t_err);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    do_access(1'b0, 16'h0010, 4'hF, 32'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    if (bus.rsp_valid_o !== 1'b0 || bus.rdata_o !== 32'h0 || bus.err_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid got=rsp%b/rd%h/err%b/rdy%b req=0/0/0/1",
               bus.rsp_valid_o, bus.rdata_o, bus.err_o, bus.ready_o);
    end
    n_cmp++;
    @(negedge clk);
    rst_ni = 1'b1;
    do_access(1'b0, 16'h0010, 4'hF, 32'h0);
    if (t_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reset_mem_kept got=%h req=deadbeef", t_rdata); end
    n_cmp++;
  endtask

  task automatic test_reset_split();
    logic seen;
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 16'h003E; bus.be_i = 4'hF; bus.wdata_i = 32'hA1B2C3D4;
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    @(negedge clk);
    if (dbg_state !== SPLIT || bus.ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rsplit_in_split got=%0d/%b req=SPLIT/0", dbg_state, bus.ready_o);
    end
    n_cmp++;
    #1;
    rst_ni = 1'b0;
    #1;
    if (dbg_state !== IDLE || bus.ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rsplit_reset got=%0d/%b/%b req=IDLE/1/0", dbg_state, bus.ready_o, bus.rsp_valid_o);
    end
    n_cmp++;
    @(negedge clk);
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen = 1'b1;
    end
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rsplit_no_rsp got=%b req=0", seen); end
    n_cmp++;
    do_access(1'b0, 16'h003E, 4'b0011, 32'h0);
    if (t_rdata !== 32'h0000C3D4) begin n_fail++; $display("FAIL rsplit_ph1_kept got=%h req=0000c3d4", t_rdata); end
    n_cmp++;
    do_access(1'b0, 16'h0040, 4'hF, 32'h0);
    if (t_rdata !== 32'h0) begin n_fail++; $display("FAIL rsplit_ph2_dropped got=%h req=0", t_rdata); end
    n_cmp++;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_ni = 1'b0;
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
    bus.addr_i = '0;
    bus.be_i = '0;
    bus.wdata_i = '0;
    test_reset();
    init_mem();
    test_aligned();
    test_partial();
    test_back_to_back();
    test_split();
    test_wrap();
    test_reset_mid();
`ifdef DMEM_MISALIGN_EN
    test_reset_split();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
